// File: rtl/keypress_tx_scheduler.sv
// Keypad-to-UART byte scheduler: qualifies the encoder output, hands one byte per
// press to the UART over a start/busy handshake and generates typematic repeats.
module keypress_tx_scheduler #(
    parameter int DATA_WIDTH    = 8,
    parameter int STABLE_CYCLES = 50000,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000,
    parameter int CNT_WIDTH     = 25
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [DATA_WIDTH-1:0] i_value,
    input  logic                  i_key_pressed,
    input  logic                  i_tx_busy,
    output logic [DATA_WIDTH-1:0] o_tx_data,
    output logic                  o_tx_start,
    output logic                  o_repeat,
    output logic                  o_busy
);

    localparam int                   IN_W        = DATA_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] STABLE_MAX  = CNT_WIDTH'(STABLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] DELAY_LOAD  = CNT_WIDTH'(REPEAT_DELAY);
    localparam logic [CNT_WIDTH-1:0] PERIOD_LOAD = CNT_WIDTH'(REPEAT_PERIOD);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO    = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE     = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO  = {DATA_WIDTH{1'b0}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        WAIT_TX = 2'd2,
        HOLD    = 2'd3
    } state_t;

    logic [IN_W-1:0]       sync1_r;
    logic [IN_W-1:0]       sync2_r;
    logic [IN_W-1:0]       prev_r;
    logic [CNT_WIDTH-1:0]  stab_cnt_r;
    logic [CNT_WIDTH-1:0]  rpt_cnt_r;
    state_t                state_r;
    logic                  wait_first_r;

    logic                  pressed_s;
    logic [DATA_WIDTH-1:0] value_s;
    logic                  changed_s;
    logic                  qualified_s;
    logic                  sendable_s;
    logic                  null_press_s;
    logic                  same_key_s;
    logic                  rpt_due_s;

    assign pressed_s    = sync2_r[DATA_WIDTH];
    assign value_s      = sync2_r[DATA_WIDTH-1:0];
    assign changed_s    = (sync2_r != prev_r);
    // The counter still holds the old run length on the first cycle of a new value.
    assign qualified_s  = !changed_s && (stab_cnt_r == STABLE_MAX);
    assign sendable_s   = pressed_s && (value_s != DATA_ZERO);
    assign null_press_s = pressed_s && (value_s == DATA_ZERO);
    assign same_key_s   = pressed_s && (value_s == o_tx_data);
    assign rpt_due_s    = (rpt_cnt_r <= CNT_ONE);

    // Start is gated by the live busy so it can never coincide with a busy UART.
    assign o_tx_start = (state_r == SEND) && !i_tx_busy;

    // Input synchronizer and saturating stability counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_r    <= {IN_W{1'b0}};
            sync2_r    <= {IN_W{1'b0}};
            prev_r     <= {IN_W{1'b0}};
            stab_cnt_r <= CNT_ZERO;
        end else begin
            sync1_r <= {i_key_pressed, i_value};
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
            if (changed_s) begin
                stab_cnt_r <= CNT_ZERO;
            end else if (stab_cnt_r < STABLE_MAX) begin
                stab_cnt_r <= stab_cnt_r + CNT_ONE;
            end else begin
                stab_cnt_r <= stab_cnt_r;
            end
        end
    end

    // Transmit scheduling FSM with registered data/repeat/busy outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r      <= IDLE;
            wait_first_r <= 1'b0;
            rpt_cnt_r    <= CNT_ZERO;
            o_tx_data    <= DATA_ZERO;
            o_repeat     <= 1'b0;
            o_busy       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (qualified_s && sendable_s) begin
                        o_tx_data <= value_s;
                        o_repeat  <= 1'b0;
                        o_busy    <= 1'b1;
                        state_r   <= SEND;
                    end else begin
                        o_busy    <= 1'b0;
                    end
                end
                SEND: begin
                    if (!i_tx_busy) begin
                        wait_first_r <= 1'b1;
                        state_r      <= WAIT_TX;
                    end else begin
                        state_r      <= SEND;
                    end
                end
                WAIT_TX: begin
                    // First cycle is a grace period for the UART to raise busy.
                    if (wait_first_r) begin
                        wait_first_r <= 1'b0;
                    end else if (!i_tx_busy) begin
                        rpt_cnt_r <= o_repeat ? PERIOD_LOAD : DELAY_LOAD;
                        state_r   <= HOLD;
                    end else begin
                        state_r   <= WAIT_TX;
                    end
                end
                HOLD: begin
                    if (qualified_s && !pressed_s) begin
                        o_repeat <= 1'b0;
                        o_busy   <= 1'b0;
                        state_r  <= IDLE;
                    end else if (qualified_s && sendable_s && (value_s != o_tx_data)) begin
                        o_tx_data <= value_s;
                        o_repeat  <= 1'b0;
                        state_r   <= SEND;
                    end else if (qualified_s && same_key_s && rpt_due_s) begin
                        o_repeat <= 1'b1;
                        state_r  <= SEND;
                    end else if (qualified_s && null_press_s) begin
                        rpt_cnt_r <= rpt_cnt_r;
                    end else if (rpt_cnt_r != CNT_ZERO) begin
                        rpt_cnt_r <= rpt_cnt_r - CNT_ONE;
                    end else begin
                        rpt_cnt_r <= CNT_ZERO;
                    end
                end
                default: begin
                    o_busy  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypress_tx_scheduler.sv
// Directed bench for keypress_tx_scheduler: a cycle model built from input history
// and elapsed-hold counts is compared every cycle, plus hand-computed start times.
module tb_keypress_tx_scheduler;

    localparam int SC = 4;
    localparam int RD = 40;
    localparam int RP = 10;
    localparam int P_IDLE = 0;
    localparam int P_SEND = 1;
    localparam int P_WAIT = 2;
    localparam int P_HOLD = 3;

    logic       clk = 1'b0;
    logic       i_rst_n;
    logic [7:0] i_value;
    logic       i_key_pressed;
    logic       i_tx_busy;
    logic [7:0] o_tx_data;
    logic       o_tx_start;
    logic       o_repeat;
    logic       o_busy;

    keypress_tx_scheduler #(
        .DATA_WIDTH(8), .STABLE_CYCLES(SC), .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP), .CNT_WIDTH(8)
    ) dut (
        .i_clk(clk), .i_rst_n(i_rst_n), .i_value(i_value),
        .i_key_pressed(i_key_pressed), .i_tx_busy(i_tx_busy),
        .o_tx_data(o_tx_data), .o_tx_start(o_tx_start),
        .o_repeat(o_repeat), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    int         log_cyc[$];
    logic [7:0] log_dat[$];
    logic       log_rep[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // UART: busy rises the cycle after a start and stays up for 8 cycles.
    bit force_busy = 1'b0;
    int busy_left  = 0;
    initial begin
        logic st;
        i_tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            st = o_tx_start;
            @(posedge clk);
            #2;
            if (st) busy_left = 8;
            else if (busy_left > 0) busy_left--;
            i_tx_busy = force_busy || (busy_left > 0);
        end
    end

    // Behavioural model: raw_hist[0] is the newest raw sample, s_in lags it by one.
    int         m_phase;
    logic [7:0] m_data;
    bit         m_rep;
    bit         m_grace;
    int         m_run;
    int         m_need;
    logic [8:0] raw_hist [0:7];

    function automatic bit m_qualified();
        for (int k = 1; k <= SC; k++)
            if (raw_hist[1 + k] != raw_hist[1]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic m_reset();
        m_phase = P_IDLE; m_data = 8'h00; m_rep = 1'b0; m_grace = 1'b0;
        m_run = 0; m_need = 0;
        for (int k = 0; k < 8; k++) raw_hist[k] = 9'h000;
    endtask

    task automatic m_step();
        logic [8:0] sin;
        bit q;
        bit bsy;
        sin = raw_hist[1];
        q   = m_qualified();
        bsy = i_tx_busy;
        case (m_phase)
            P_IDLE: if (q && sin[8] && sin[7:0] != 8'h00) begin
                m_data = sin[7:0]; m_rep = 1'b0; m_phase = P_SEND;
            end
            P_SEND: if (!bsy) begin
                m_phase = P_WAIT; m_grace = 1'b1;
            end
            P_WAIT: if (m_grace) m_grace = 1'b0;
                    else if (!bsy) begin
                        m_phase = P_HOLD; m_run = 0; m_need = m_rep ? RP : RD;
                    end
            P_HOLD: begin
                if (q && !sin[8]) begin
                    m_phase = P_IDLE; m_rep = 1'b0;
                end else if (q && sin[8] && sin[7:0] != 8'h00 && sin[7:0] != m_data) begin
                    m_data = sin[7:0]; m_rep = 1'b0; m_phase = P_SEND;
                end else if (q && sin == {1'b1, m_data} && m_run + 1 >= m_need) begin
                    m_rep = 1'b1; m_phase = P_SEND;
                end else if (!(q && sin == 9'h100)) begin
                    m_run++;
                end
            end
            default: m_phase = P_IDLE;
        endcase
        for (int k = 7; k > 0; k--) raw_hist[k] = raw_hist[k - 1];
        raw_hist[0] = {i_key_pressed, i_value};
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge i_rst_n);
            if (!i_rst_n) m_reset();
            else m_step();
        end
    end

    // Per-cycle comparison against the model, and a log of every start pulse.
    initial begin
        forever begin
            @(negedge clk);
            if (!i_rst_n) begin
                chk("rst_start", 32'(o_tx_start), 32'(0));
                chk("rst_data",  32'(o_tx_data),  32'(0));
                chk("rst_repeat", 32'(o_repeat),  32'(0));
                chk("rst_busy",  32'(o_busy),     32'(0));
            end else begin
                chk("tx_start", 32'(o_tx_start), 32'((m_phase == P_SEND) && !i_tx_busy));
                chk("tx_data",  32'(o_tx_data),  32'(m_data));
                chk("repeat",   32'(o_repeat),   32'(m_rep));
                chk("busy",     32'(o_busy),     32'(m_phase != P_IDLE));
                if (o_tx_start) begin
                    log_cyc.push_back(cyc);
                    log_dat.push_back(o_tx_data);
                    log_rep.push_back(o_repeat);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_key(input logic p, input logic [7:0] v);
        i_key_pressed = p;
        i_value       = v;
    endtask

    task automatic exp_start(input string tag, input int base, input int k,
                             input int t_exp, input logic [7:0] d, input logic r);
        if (base + k < log_cyc.size()) begin
            chk({tag, "_cycle"},  32'(log_cyc[base + k]), 32'(t_exp));
            chk({tag, "_data"},   32'(log_dat[base + k]), 32'(d));
            chk({tag, "_repeat"}, 32'(log_rep[base + k]), 32'(r));
        end else begin
            chk({tag, "_present"}, 32'(log_cyc.size()), 32'(base + k + 1));
        end
    endtask

    int base;
    int t0;
    int t_mark;

    initial begin
        i_rst_n = 1'b0;
        set_key(1'b0, 8'h00);
        step(3);
        i_rst_n = 1'b1;
        step(2);
        @(negedge clk);
        chk("post_reset_busy", 32'(o_busy), 32'(0));
        chk("post_reset_data", 32'(o_tx_data), 32'(0));

        // Single press
        step(1);
        base = log_cyc.size(); set_key(1'b1, 8'h61); t0 = cyc;
        step(20); set_key(1'b0, 8'h00); step(30);
        chk("single_count", 32'(log_cyc.size() - base), 32'(1));
        exp_start("single", base, 0, t0 + 7, 8'h61, 1'b0);
        @(negedge clk);
        chk("single_idle", 32'(o_busy), 32'(0));

        // Bounce, then settle on 0x73
        step(1);
        base = log_cyc.size();
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0) set_key(1'b1, 8'h73);
            else set_key(1'b0, 8'h00);
            step(2);
        end
        chk("bounce_quiet", 32'(log_cyc.size() - base), 32'(0));
        set_key(1'b1, 8'h73); t0 = cyc;
        step(25); set_key(1'b0, 8'h00); step(30);
        chk("bounce_count", 32'(log_cyc.size() - base), 32'(1));
        exp_start("bounce", base, 0, t0 + 7, 8'h73, 1'b0);

        // Auto-repeat: 7, then 17+40, then each 10 cycles after busy clears
        base = log_cyc.size(); set_key(1'b1, 8'h77); t0 = cyc;
        step(100); set_key(1'b0, 8'h00); step(30);
        chk("repeat_count", 32'(log_cyc.size() - base), 32'(4));
        exp_start("repeat0", base, 0, t0 + 7,  8'h77, 1'b0);
        exp_start("repeat1", base, 1, t0 + 57, 8'h77, 1'b1);
        exp_start("repeat2", base, 2, t0 + 77, 8'h77, 1'b1);
        exp_start("repeat3", base, 3, t0 + 97, 8'h77, 1'b1);

        // Chord change during HOLD
        base = log_cyc.size(); set_key(1'b1, 8'h77); t0 = cyc;
        step(20); set_key(1'b1, 8'h23); step(20);
        set_key(1'b0, 8'h00); step(40);
        chk("chord_count", 32'(log_cyc.size() - base), 32'(2));
        exp_start("chord0", base, 0, t0 + 7,  8'h77, 1'b0);
        exp_start("chord1", base, 1, t0 + 27, 8'h23, 1'b0);

        // Busy backpressure: byte waits in SEND until busy drops
        force_busy = 1'b1; step(2);
        base = log_cyc.size(); set_key(1'b1, 8'h64); t0 = cyc;
        step(14);
        @(negedge clk);
        chk("bp_busy", 32'(o_busy), 32'(1));
        chk("bp_data", 32'(o_tx_data), 32'(8'h64));
        chk("bp_nostart", 32'(log_cyc.size() - base), 32'(0));
        @(posedge clk); #1;
        force_busy = 1'b0; t_mark = cyc;
        step(15); set_key(1'b0, 8'h00); step(30);
        chk("bp_count", 32'(log_cyc.size() - base), 32'(1));
        exp_start("bp", base, 0, t_mark, 8'h64, 1'b0);

        // Reset during WAIT_TX with the key still held
        base = log_cyc.size(); set_key(1'b1, 8'h26); t0 = cyc;
        step(10);
        chk("mid_busy", 32'(o_busy), 32'(1));
        i_rst_n = 1'b0;
        #1;
        chk("async_start",  32'(o_tx_start), 32'(0));
        chk("async_data",   32'(o_tx_data),  32'(0));
        chk("async_repeat", 32'(o_repeat),   32'(0));
        chk("async_busy",   32'(o_busy),     32'(0));
        step(3);
        i_rst_n = 1'b1; t_mark = cyc;
        step(25); set_key(1'b0, 8'h00); step(40);
        chk("rst_count", 32'(log_cyc.size() - base), 32'(2));
        exp_start("rst_pre",  base, 0, t0 + 7,     8'h26, 1'b0);
        exp_start("rst_post", base, 1, t_mark + 7, 8'h26, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/keypress_tx_scheduler.md
Name: keypress_tx_scheduler

Overview:
- Consumes the encoded key byte and the key-pressed flag from the keypad encoder.
- Qualifies them as stable, then issues one byte per press to the downstream UART transmitter over a start/busy handshake.
- Generates typematic auto-repeat while a key combination is held.
- Sits between the keypad encoder and the UART TX datapath on the CPLD.

Parameters:
- DATA_WIDTH, 8, width of encoded key value and TX byte
- STABLE_CYCLES, 50000, cycles input must be unchanged to be qualified (1 ms @ 50 MHz)
- REPEAT_DELAY, 25000000, cycles from first send to first repeat (0.5 s)
- REPEAT_PERIOD, 5000000, cycles between subsequent repeats (0.1 s)
- CNT_WIDTH, 25, width of the shared timer; must hold max(STABLE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)

Ports:
- i_clk  input  1  system clock
- i_rst_n  input  1  asynchronous active-low reset
- i_value  input  DATA_WIDTH  encoded key value from encoder (0 = null)
- i_key_pressed  input  1  any key pressed, from encoder
- i_tx_busy  input  1  UART TX busy
- o_tx_data  output  DATA_WIDTH  byte to transmit, held stable from start until busy falls
- o_tx_start  output  1  one-cycle transmit request
- o_repeat  output  1  high while the current byte is an auto-repeat
- o_busy  output  1  high in any state other than IDLE

Behaviour:
- Reset is asynchronous, active-low. All flops clear: o_tx_data=0, o_tx_start=0, o_repeat=0, o_busy=0, state=IDLE, timer=0, sync flops=0.
- Input conditioning:
  - {i_key_pressed, i_value} passes through a 2-flop synchronizer per bit; the result is called s_in.
  - A stability timer clears whenever s_in differs from its previous-cycle value, otherwise increments, saturating.
  - s_in is "qualified" when the timer reaches STABLE_CYCLES-1, i.e. unchanged for STABLE_CYCLES cycles.
  - Input-to-qualify latency is 2 + STABLE_CYCLES cycles.
- A qualified pattern is "sendable" if pressed=1 and value≠0. A null value with pressed=1 (invalid combination) is not sendable.
- FSM states:
  - IDLE: waits for a qualified sendable pattern, then latches value into o_tx_data and goes to SEND.
  - SEND:
    - If i_tx_busy=0: pulse o_tx_start for exactly 1 cycle and go to WAIT_TX.
    - Otherwise stay in SEND, holding o_tx_data.
  - WAIT_TX:
    - Ignore i_tx_busy on the first cycle, giving the UART one cycle to raise busy.
    - Then wait for i_tx_busy=0, load the repeat timer (REPEAT_DELAY if o_repeat=0, else REPEAT_PERIOD), and go to HOLD.
  - HOLD: timer decrements each cycle. Conditions are checked in this priority order:
    - (a) s_in pressed=0, qualified: go to IDLE, o_repeat=0.
    - (b) qualified sendable value ≠ o_tx_data (chord change, e.g. w→w+a): latch the new value, o_repeat=0, go to SEND immediately.
    - (c) timer expires with s_in unchanged and equal to o_tx_data: o_repeat=1, go to SEND.
    - (d) qualified null value with pressed=1: stay in HOLD, timer frozen, no repeats.
- Unqualified (bouncing) input in HOLD has no effect; the repeat timer keeps running.
- A release or change during SEND/WAIT_TX is deferred. The in-flight byte always completes, and HOLD evaluates the change on entry.
- o_tx_start never asserts while i_tx_busy=1, and never on two consecutive cycles.
- o_tx_data changes only in IDLE→SEND or HOLD→SEND transitions.
- Reset mid-transfer: all outputs drop at once. On reset release the FSM is in IDLE, and a still-held key is resent after requalification.
- Timers saturate; there is no wrap. With REPEAT_PERIOD=1, a repeat is issued as soon as the UART is free.

Test Plan (STABLE_CYCLES=4, REPEAT_DELAY=40, REPEAT_PERIOD=10; UART model raises busy 1 cycle after start, holds 8 cycles):
- Single press: value=0x61, pressed=1 held 20 cycles, then released → exactly one o_tx_start with o_tx_data=0x61 at cycle 7 after input change, o_repeat=0; back to IDLE.
- Bounce: toggle pressed/value 0x73↔0 every 2 cycles for 20 cycles, then hold 0x73 → no start during bounce; one start with 0x73 after 4 stable cycles.
- Auto-repeat: hold 0x77 for 100 cycles → first send, repeat 40 cycles after busy falls, then every 10+busy cycles. Repeats have o_repeat=1 and data 0x77; sends stop within 6 cycles of release.
- Chord change: hold 0x77, then after first send switch to 0x23 → next start carries 0x23 with o_repeat=0, without waiting for REPEAT_DELAY.
- Busy backpressure: tie i_tx_busy=1 and press 0x64 → state SEND, no start, o_tx_data=0x64. Drop busy → start on that same cycle.
- Reset mid-transfer: assert i_rst_n=0 during WAIT_TX → all outputs 0 asynchronously. Release reset with 0x26 held → one fresh send of 0x26.
